// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Handshaked integer ALU with one operation in flight. Logic, add,
//            subtract, multiply and shift complete in one cycle. DIV/MOD run
//            an iterative restoring divider over WIDTH cycles.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - operation request
//            in_ready   - request accepted this cycle
//            op[3:0]    - opcode
//            d0, d1     - left / right operands
//            out_valid  - result available
//            out_ready  - consumer takes result
//            dout       - result (d0 op d1)
//            dz         - divide-by-zero status, qualified by out_valid
//            ill        - illegal-opcode status, qualified by out_valid
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_DIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dz,
    output logic             ill
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] c_OP_OR  = 4'h0;
    localparam logic [3:0] c_OP_XOR = 4'h1;
    localparam logic [3:0] c_OP_AND = 4'h2;
    localparam logic [3:0] c_OP_ADD = 4'h4;
    localparam logic [3:0] c_OP_SUB = 4'h5;
    localparam logic [3:0] c_OP_MUL = 4'h6;
    localparam logic [3:0] c_OP_SHL = 4'h8;
    localparam logic [3:0] c_OP_SAR = 4'h9;
    localparam logic [3:0] c_OP_DIV = 4'hA;
    localparam logic [3:0] c_OP_MOD = 4'hB;

    localparam logic [WIDTH-1:0] c_WIDTH_V  = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    c_CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]    c_CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             dz_q, dz_d;
    logic             ill_q, ill_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder, always < divisor
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic             negq_q, negq_d;   // quotient needs negation at the end
    logic             negr_q, negr_d;   // remainder needs negation at the end
    logic             mod_q, mod_d;     // 1 = MOD result wanted, 0 = DIV

    // ------------------------------------------------------------------
    // Single-cycle result path (also supplies the divide-by-zero result)
    // ------------------------------------------------------------------
    logic             w_big;
    logic [SHW-1:0]   w_sha;
    logic [WIDTH-1:0] w_sres;
    logic             w_sdz;
    logic             w_sill;

    always_comb begin
        // An amount of WIDTH or more saturates; below that the low SHW bits
        // carry the whole amount, even for non-power-of-two widths.
        w_big  = (d1 >= c_WIDTH_V);
        w_sha  = d1[SHW-1:0];
        w_sres = '0;
        w_sdz  = 1'b0;
        w_sill = 1'b0;
        case (op)
            c_OP_OR:  w_sres = d0 | d1;
            c_OP_XOR: w_sres = d0 ^ d1;
            c_OP_AND: w_sres = d0 & d1;
            c_OP_ADD: w_sres = d0 + d1;
            c_OP_SUB: w_sres = d0 - d1;
            c_OP_MUL: w_sres = d0 * d1;
            c_OP_SHL: w_sres = w_big ? '0 : (d0 << w_sha);
            c_OP_SAR: w_sres = w_big ? {WIDTH{d0[WIDTH-1]}}
                                     : WIDTH'($signed(d0) >>> w_sha);
            // Only reaches the result register when d1 is zero.
            c_OP_DIV: begin
                w_sres = '1;
                w_sdz  = 1'b1;
            end
            c_OP_MOD: begin
                w_sres = d0;
                w_sdz  = 1'b1;
            end
            default:  w_sill = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Divider setup and one restoring iteration
    // ------------------------------------------------------------------
    logic             w_is_div;
    logic             w_d1_zero;
    logic             w_d0_neg;
    logic             w_d1_neg;
    logic [WIDTH-1:0] w_d0_mag;
    logic [WIDTH-1:0] w_d1_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    always_comb begin
        w_is_div  = (op == c_OP_DIV) || (op == c_OP_MOD);
        w_d1_zero = (d1 == '0);
        w_d0_neg  = SIGNED_DIV && d0[WIDTH-1];
        w_d1_neg  = SIGNED_DIV && d1[WIDTH-1];
        // Magnitude of MIN wraps to itself, which read unsigned is correct.
        w_d0_mag  = w_d0_neg ? (-d0) : d0;
        w_d1_mag  = w_d1_neg ? (-d1) : d1;

        w_shift = {rem_q, quo_q[WIDTH-1]};
        w_trial = w_shift - {1'b0, dvs_q};
        if (!w_trial[WIDTH]) begin
            w_rem_nx = w_trial[WIDTH-1:0];
            w_quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            // Restore: a negative trial means the shifted value was below
            // the divisor, so its top bit is known to be zero.
            w_rem_nx = w_shift[WIDTH-1:0];
            w_quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        end

        w_quo_fix = negq_q ? (-w_quo_nx) : w_quo_nx;
        w_rem_fix = negr_q ? (-w_rem_nx) : w_rem_nx;
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        dz_d    = dz_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        mod_d   = mod_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_is_div && !w_d1_zero) begin
                        quo_d   = w_d0_mag;
                        rem_d   = '0;
                        dvs_d   = w_d1_mag;
                        negq_d  = w_d0_neg ^ w_d1_neg;
                        negr_d  = w_d0_neg;
                        mod_d   = (op == c_OP_MOD);
                        cnt_d   = c_CNT_LOAD;
                        state_d = S_BUSY;
                    end else begin
                        res_d   = w_sres;
                        dz_d    = w_sdz;
                        ill_d   = w_sill;
                        state_d = S_HOLD;
                    end
                end
            end
            S_BUSY: begin
                quo_d = w_quo_nx;
                rem_d = w_rem_nx;
                cnt_d = cnt_q - c_CNT_ONE;
                if (cnt_q == c_CNT_ONE) begin
                    res_d   = mod_q ? w_rem_fix : w_quo_fix;
                    dz_d    = 1'b0;
                    ill_d   = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            mod_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            mod_q   <= mod_d;
        end
    end

    // in_ready is gated by rst_n because reset parks the FSM in IDLE,
    // yet nothing may be accepted while reset is held.
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign dout      = res_q;
    assign dz        = dz_q;
    assign ill       = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Scoreboard bench for seq_alu. Stimulus pushes the expected
//            response; a monitor pops and compares on each output handshake.
//            A second instance checks unsigned division.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, dz, ill;
    logic [3:0]   op;
    logic [W-1:0] d0, d1, dout;

    logic         u_in_valid, u_in_ready, u_out_valid, u_dz, u_ill;
    logic [3:0]   u_op;
    logic [W-1:0] u_d0, u_d1, u_dout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         dz;
        logic         ill;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_alu #(.WIDTH(W), .SIGNED_DIV(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .d0(d0), .d1(d1),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .dz(dz), .ill(ill)
    );

    seq_alu #(.WIDTH(W), .SIGNED_DIV(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n),
        .in_valid(u_in_valid), .in_ready(u_in_ready), .op(u_op), .d0(u_d0), .d1(u_d1),
        .out_valid(u_out_valid), .out_ready(1'b1),
        .dout(u_dout), .dz(u_dz), .ill(u_ill)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called at a falling edge. Waits for in_ready, drives one request and
    // returns at the falling edge after the accepting edge.
    task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] r, input logic z,
                         input logic il, input int lat, input bit push);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready stayed %b, required 1", name, in_ready);
            return;
        end
        op = o; d0 = a; d1 = b; in_valid = 1'b1;
        if (push) sb.push_back('{name, r, z, il, cyc + 1, lat});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic udiv(input string name, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r);
        int n = 0;
        int start;
        u_op = o; u_d0 = a; u_d1 = b; u_in_valid = 1'b1;
        start = cyc + 1;
        @(negedge clk);
        u_in_valid = 1'b0;
        while (!u_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, {31'd0, u_out_valid}, 32'd1);
        check(name, u_dout, r);
        check({name, "_lat"}, W'(cyc - start), 32'd32);
        @(negedge clk);
    endtask

    // Monitor: samples just after the falling edge, i.e. the values the
    // next rising edge will see.
    bit seen = 1'b0;
    int first_cyc = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                seen = 1'b0;
            end else begin
                if (out_valid && !seen) begin
                    seen      = 1'b1;
                    first_cyc = cyc;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out: got dout %h with empty scoreboard", dout);
                    end else begin
                        e = sb.pop_front();
                        check(e.name, dout, e.res);
                        check({e.name, "_flags"}, {30'd0, dz, ill}, {30'd0, e.dz, e.ill});
                        check({e.name, "_lat"}, W'(first_cyc - e.acc), W'(e.lat));
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 4'h0; d0 = '0; d1 = '0;
        u_in_valid = 1'b0; u_op = 4'h0; u_d0 = '0; u_d1 = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_flags", {30'd0, dz, ill}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First op: latency and in_ready return checked explicitly.
        issue("add_ovf", 4'h4, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 1);
        check("add_out_valid", {31'd0, out_valid}, 32'd1);
        check("add_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("add_in_ready_back", {31'd0, in_ready}, 32'd1);

        issue("or",     4'h0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 0, 0, 0, 1);
        issue("xor",    4'h1, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 0, 0, 0, 1);
        issue("and",    4'h2, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0, 0, 0, 1);
        issue("sub",    4'h5, 32'h0,        32'h1,        32'hFFFFFFFF, 0, 0, 0, 1);
        issue("sar4",   4'h9, 32'h80000000, 32'd4,        32'hF8000000, 0, 0, 0, 1);
        issue("sar31",  4'h9, 32'h80000000, 32'd31,       32'hFFFFFFFF, 0, 0, 0, 1);
        issue("sar33",  4'h9, 32'h80000000, 32'd33,       32'hFFFFFFFF, 0, 0, 0, 1);
        issue("shl4",   4'h8, 32'h1,        32'd4,        32'h00000010, 0, 0, 0, 1);
        issue("shl31",  4'h8, 32'h1,        32'd31,       32'h80000000, 0, 0, 0, 1);
        issue("shl32",  4'h8, 32'h1,        32'd32,       32'h0,        0, 0, 0, 1);
        issue("shl40",  4'h8, 32'h1,        32'd40,       32'h0,        0, 0, 0, 1);
        issue("mul0",   4'h6, 32'h10000,    32'h10000,    32'h0,        0, 0, 0, 1);
        issue("mul",    4'h6, 32'd1234,     32'd1000,     32'd1234000,  0, 0, 0, 1);
        issue("div_m7_2",   4'hA, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 32, 1);
        issue("mod_m7_2",   4'hB, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0, 32, 1);
        issue("div_7_m2",   4'hA, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 32, 1);
        issue("mod_7_m2",   4'hB, 32'd7,        32'hFFFFFFFE, 32'd1,        0, 0, 32, 1);
        issue("div_100_7",  4'hA, 32'd100,      32'd7,        32'd14,       0, 0, 32, 1);
        issue("mod_100_7",  4'hB, 32'd100,      32'd7,        32'd2,        0, 0, 32, 1);
        issue("div_min_m1", 4'hA, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 32, 1);
        issue("mod_min_m1", 4'hB, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 0, 32, 1);
        issue("div_5_0",    4'hA, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, 0, 1);
        issue("mod_5_0",    4'hB, 32'd5,        32'd0,        32'd5,        1, 0, 0, 1);
        issue("ill_c",      4'hC, 32'd5,        32'd3,        32'h0,        0, 1, 0, 1);
        issue("ill_3",      4'h3, 32'hFFFF,     32'd3,        32'h0,        0, 1, 0, 1);
        issue("ill_7",      4'h7, 32'd9,        32'd9,        32'h0,        0, 1, 0, 1);

        // Unsigned divider instance.
        udiv("udiv", 4'hA, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC);
        udiv("umod", 4'hB, 32'hFFFFFFF9, 32'd2, 32'd1);

        // Backpressure: result held, new requests ignored.
        out_ready = 1'b0;
        issue("bp_add", 4'h4, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_dout", dout, 32'd5);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            if (i == 1) begin
                in_valid = 1'b1; op = 4'h5; d0 = 32'd9; d1 = 32'd1;
            end
            if (i == 2) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a division.
        issue("div_abort", 4'hA, 32'd100, 32'd7, 32'd0, 0, 0, 0, 0);
        repeat (10) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_dout", dout, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue("post_rst_add", 4'h4, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("sb_drained", W'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
